multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. Sequences fetch/decode/execute/mem/writeback
//  per opcode. Drives every datapath select and strobe, including reg_dst, the select of the 5-bit

---
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction,
// drives all datapath selects/strobes, stalls on mem_ready and traps on faults.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       exc,
    output logic [1:0] exc_cause
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             cnt_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Last permitted wait cycle: the counter holds the number of waits already spent.
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        exc           = 1'b0;
        exc_cause     = cause_q;

        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (cnt_last) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'd1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (cnt_last) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (cnt_last) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                exc       = 1'b1;
                pc_write  = 1'b1;
                pc_source = 2'd3;
                state_d   = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
    end

    // Only memory states ever hold, so a self-loop means a wait cycle; any transition clears.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, corner-case
// sequences, then randomized instructions against an instruction-level model.
module tb_multicycle_ctrl;

    localparam int unsigned TIMEOUT = 15;

    logic       clk, rst_n;
    logic [5:0] opcode;
    logic       mem_ready, zero;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, exc;
    logic [1:0] alu_src_b, alu_op, pc_source, exc_cause;

    multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .exc(exc), .exc_cause(exc_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD = 6'b111111;

    // Word layout: pcw pcwc iord mrd mwr irw m2r rdst rw sa sb[2] aop[2] psrc[2] exc cause[2]
    function automatic logic [18:0] mk(input int pcw, pcwc, io, mrd, mwr, irw, m2r,
                                       rdst, rw, sa, sb, aop, psrc, ex);
        return {pcw[0], pcwc[0], io[0], mrd[0], mwr[0], irw[0], m2r[0], rdst[0], rw[0],
                sa[0], sb[1:0], aop[1:0], psrc[1:0], ex[0], 2'b00};
    endfunction

    localparam logic [18:0] W_IDLE  = 19'd0;
    localparam logic [18:0] W_F_RDY = mk(1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    localparam logic [18:0] W_F_WT  = mk(0,0,0,1,0,0,0,0,0,0,1,0,0,0);
    localparam logic [18:0] W_DEC   = mk(0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    localparam logic [18:0] W_ADDR  = mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0);
    localparam logic [18:0] W_RD    = mk(0,0,1,1,0,0,0,0,0,0,0,0,0,0);
    localparam logic [18:0] W_MWB   = mk(0,0,0,0,0,0,1,0,1,0,0,0,0,0);
    localparam logic [18:0] W_WR    = mk(0,0,1,0,1,0,0,0,0,0,0,0,0,0);
    localparam logic [18:0] W_REX   = mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0);
    localparam logic [18:0] W_RWB   = mk(0,0,0,0,0,0,0,1,1,0,0,0,0,0);
    localparam logic [18:0] W_IWB   = mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0);
    localparam logic [18:0] W_BR    = mk(0,1,0,0,0,0,0,0,0,1,0,1,1,0);
    localparam logic [18:0] W_J     = mk(1,0,0,0,0,0,0,0,0,0,0,0,2,0);
    localparam logic [18:0] W_TRAP  = mk(1,0,0,0,0,0,0,0,0,0,0,0,3,1);

    int checks = 0;
    int errors = 0;
    int rw_count;

    function automatic logic [18:0] got_word();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, exc, exc_cause};
    endfunction

    task automatic check(input string name, input logic [18:0] exp);
        logic [18:0] got;
        got = got_word();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
        end
    endtask

    // Entered at posedge+1: drive, settle, compare, advance one clock.
    task automatic step(input logic [5:0] op, input logic mr, input logic z,
                        input logic [18:0] exp, input string name);
        opcode = op; mem_ready = mr; zero = z;
        #1;
        check(name, exp);
        if (reg_write) rw_count++;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic        z;
        logic [18:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] op, input logic mr, input logic z,
                       input logic [18:0] exp, input string name);
        vec_t v;
        v.op = op; v.mr = mr; v.z = z; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    typedef enum int {PH_FETCH, PH_RD, PH_WR, PH_PLAN} ph_t;
    typedef struct {
        logic [18:0] w;
        logic [1:0]  cause;
    } pe_t;

    pe_t        plan[$];
    ph_t        ph, after;
    int         waits;
    logic [1:0] cause_m;
    logic [5:0] cur_op;
    logic       stuck;
    logic [5:0] ops [8];

    // Instruction-level schedule: the non-memory cycles each opcode needs after fetch.
    task automatic load_plan(input logic [5:0] op);
        plan.push_back('{W_DEC, 2'd0});
        case (op)
            OP_R:    begin plan.push_back('{W_REX, 2'd0}); plan.push_back('{W_RWB, 2'd0}); end
            OP_LW:   begin plan.push_back('{W_ADDR, 2'd0}); after = PH_RD; end
            OP_SW:   begin plan.push_back('{W_ADDR, 2'd0}); after = PH_WR; end
            OP_BEQ:  plan.push_back('{W_BR, 2'd0});
            OP_J:    plan.push_back('{W_J, 2'd0});
            OP_ADDI: begin plan.push_back('{W_ADDR, 2'd0}); plan.push_back('{W_IWB, 2'd0}); end
            default: plan.push_back('{W_TRAP, 2'd1});
        endcase
    endtask

    task automatic mem_wait();
        waits++;
        if (waits == int'(TIMEOUT)) begin
            plan.push_back('{W_TRAP, 2'd2});
            ph    = PH_PLAN;
            after = PH_FETCH;
        end
    endtask

    initial begin
        logic [18:0] exp;
        logic        mr;
        pe_t         e;

        rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        add(OP_R,    1, 0, W_IDLE,       "rst_state");
        add(OP_R,    1, 0, W_F_RDY,      "r_fetch");
        add(OP_R,    1, 0, W_DEC,        "r_decode");
        add(OP_R,    1, 0, W_REX,        "r_exec");
        add(OP_R,    1, 0, W_RWB,        "r_wb");
        add(OP_LW,   1, 0, W_F_RDY,      "lw_fetch");
        add(OP_LW,   1, 0, W_DEC,        "lw_decode");
        add(OP_LW,   1, 0, W_ADDR,       "lw_addr");
        add(OP_LW,   1, 0, W_RD,         "lw_rd");
        add(OP_LW,   1, 0, W_MWB,        "lw_wb");
        add(OP_BEQ,  1, 1, W_F_RDY,      "beq1_fetch");
        add(OP_BEQ,  1, 1, W_DEC,        "beq1_decode");
        add(OP_BEQ,  1, 1, W_BR,         "beq1_branch");
        add(OP_BEQ,  1, 0, W_F_RDY,      "beq0_fetch");
        add(OP_BEQ,  1, 0, W_DEC,        "beq0_decode");
        add(OP_BEQ,  1, 0, W_BR,         "beq0_branch");
        add(OP_J,    1, 0, W_F_RDY,      "j_fetch");
        add(OP_J,    1, 0, W_DEC,        "j_decode");
        add(OP_J,    1, 0, W_J,          "j_jump");
        add(OP_SW,   1, 0, W_F_RDY,      "sw_fetch");
        add(OP_SW,   1, 0, W_DEC,        "sw_decode");
        add(OP_SW,   1, 0, W_ADDR,       "sw_addr");
        add(OP_SW,   0, 0, W_WR,         "sw_wr_wait");
        add(OP_SW,   1, 0, W_WR,         "sw_wr");
        add(OP_ADDI, 0, 0, W_F_WT,       "addi_fetch_wait");
        add(OP_ADDI, 1, 0, W_F_RDY,      "addi_fetch");
        add(OP_ADDI, 1, 0, W_DEC,        "addi_decode");
        add(OP_ADDI, 1, 0, W_ADDR,       "addi_exec");
        add(OP_ADDI, 1, 0, W_IWB,        "addi_wb");
        add(OP_BAD,  1, 0, W_F_RDY,      "bad_fetch");
        add(OP_BAD,  1, 0, W_DEC,        "bad_decode");
        add(OP_BAD,  1, 0, W_TRAP | 2'd1, "bad_trap");

        foreach (tbl[i]) step(tbl[i].op, tbl[i].mr, tbl[i].z, tbl[i].exp, tbl[i].name);

        // Fetch timeout: 15 waits then TRAP with cause 2, no IR load.
        for (int i = 0; i < int'(TIMEOUT); i++) step(OP_R, 0, 0, W_F_WT | 2'd1, "to_wait");
        step(OP_R, 0, 0, W_TRAP | 2'd2, "to_trap");
        // mem_ready arriving on the last allowed wait cycle wins.
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) step(OP_R, 0, 0, W_F_WT | 2'd2, "edge_wait");
        step(OP_R, 1, 0, W_F_RDY | 2'd2, "edge_fetch");
        step(OP_R, 1, 0, W_DEC | 2'd2,   "edge_decode");
        step(OP_R, 1, 0, W_REX | 2'd2,   "edge_exec");
        step(OP_R, 1, 0, W_RWB | 2'd2,   "edge_wb");

        // lw with three stall cycles in MEM_RD: 8 cycles, one reg_write pulse.
        rw_count = 0;
        step(OP_LW, 1, 0, W_F_RDY | 2'd2, "lws_fetch");
        step(OP_LW, 1, 0, W_DEC | 2'd2,   "lws_decode");
        step(OP_LW, 1, 0, W_ADDR | 2'd2,  "lws_addr");
        for (int i = 0; i < 3; i++) step(OP_LW, 0, 0, W_RD | 2'd2, "lws_stall");
        step(OP_LW, 1, 0, W_RD | 2'd2,    "lws_rd");
        step(OP_LW, 1, 0, W_MWB | 2'd2,   "lws_wb");
        step(OP_LW, 0, 0, W_F_WT | 2'd2,  "lws_next_fetch");
        checks++;
        if (rw_count != 1) begin
            errors++;
            $display("FAIL lws_rw_pulses got=%0d expected=1", rw_count);
        end

        // Async reset during MEM_WR.
        step(OP_SW, 1, 0, W_F_RDY | 2'd2, "rsw_fetch");
        step(OP_SW, 1, 0, W_DEC | 2'd2,   "rsw_decode");
        step(OP_SW, 1, 0, W_ADDR | 2'd2,  "rsw_addr");
        mem_ready = 1'b0;
        #1 check("rsw_wr", W_WR | 2'd2);
        rst_n = 1'b0;
        #1 check_bit("rsw_async_mem_write", mem_write, 1'b0);
        check("rsw_async_all", W_IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(OP_SW, 1, 0, W_IDLE, "rsw_rst_state");

        // Randomized instructions against the schedule model.
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BAD, 6'b000001};
        ph = PH_PLAN; after = PH_FETCH; cause_m = 2'd0; waits = 0;
        cur_op = OP_R; stuck = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (ph == PH_PLAN && plan.size() == 0) begin
                ph    = after;
                after = PH_FETCH;
                waits = 0;
                if (ph == PH_FETCH) begin
                    cur_op = ops[$urandom_range(0, 7)];
                    stuck  = ($urandom_range(0, 9) == 0);
                end
            end
            mr = stuck ? 1'b0 : ($urandom_range(0, 3) != 0);
            opcode = cur_op; mem_ready = mr; zero = 1'($urandom_range(0, 1));
            #1;
            exp = W_IDLE;
            case (ph)
                PH_FETCH: begin
                    exp = mr ? W_F_RDY : W_F_WT;
                    if (mr) begin load_plan(cur_op); ph = PH_PLAN; end
                    else mem_wait();
                end
                PH_RD: begin
                    exp = W_RD;
                    if (mr) begin plan.push_back('{W_MWB, 2'd0}); ph = PH_PLAN; end
                    else mem_wait();
                end
                PH_WR: begin
                    exp = W_WR;
                    if (mr) ph = PH_PLAN;
                    else mem_wait();
                end
                default: begin
                    e = plan.pop_front();
                    if (e.cause != 2'd0) cause_m = e.cause;
                    exp = e.w;
                end
            endcase
            check("rand", exp | {17'd0, cause_m});
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
